// File: rtl/keypad_entry_if.sv
// Signal bundle between the keypad scanner / ATM controller and keypad_entry.
// The master side drives the keystrokes; the slave side (keypad_entry) returns the entry results.
interface keypad_entry_if;
    logic        start;
    logic        mode;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        busy;
    logic [2:0]  digit_count;
    logic [15:0] pin_input;
    logic [15:0] amount;
    logic        entry_valid;
    logic        entry_cancel;
    logic [7:0]  entry_error;

    modport master (
        output start, mode, key_valid, key_code,
        input  busy, digit_count, pin_input, amount, entry_valid, entry_cancel, entry_error
    );

    modport slave (
        input  start, mode, key_valid, key_code,
        output busy, digit_count, pin_input, amount, entry_valid, entry_cancel, entry_error
    );
endinterface

// File: rtl/keypad_entry.sv
// Keypad entry collector: gathers a 4-digit BCD PIN or a decimal amount (converted to binary)
// for the ATM controller, with clear/backspace/cancel editing and an inactivity timeout.
module keypad_entry #(
    parameter int unsigned PIN_DIGITS     = 4,
    parameter int unsigned AMT_DIGITS     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TW             = 10
) (
    input logic           clk,
    input logic           rst,
    keypad_entry_if.slave kp
);
    localparam int unsigned BW = 4 * AMT_DIGITS;

    localparam logic [2:0]    PIN_CNT  = 3'(PIN_DIGITS);
    localparam logic [2:0]    AMT_CNT  = 3'(AMT_DIGITS);
    localparam logic [2:0]    LAST_IDX = 3'(AMT_DIGITS - 1);
    localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_BACK   = 4'hB;
    localparam logic [3:0] KEY_ENTER  = 4'hC;
    localparam logic [3:0] KEY_CANCEL = 4'hD;

    localparam logic [7:0] ERR_NONE    = 8'h00;
    localparam logic [7:0] ERR_TIMEOUT = 8'h05;
    localparam logic [7:0] ERR_SHORT   = 8'h06;
    localparam logic [7:0] ERR_OVF     = 8'h07;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state_q;
    logic          mode_q;
    logic [BW-1:0] buf_q;
    logic [2:0]    count_q;
    logic [TW-1:0] timer_q;
    logic [16:0]   acc_q;
    logic [2:0]    conv_idx_q;
    logic [15:0]   pin_q;
    logic [15:0]   amount_q;
    logic          valid_q;
    logic          cancel_q;
    logic [7:0]    error_q;

    logic [3:0]    digit_msb;
    logic [16:0]   acc_d;
    logic [2:0]    limit;

    assign digit_msb = buf_q[BW-1 -: 4];
    assign acc_d     = (acc_q * 17'd10) + {13'd0, digit_msb};
    assign limit     = mode_q ? AMT_CNT : PIN_CNT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            buf_q      <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            acc_q      <= '0;
            conv_idx_q <= '0;
            pin_q      <= '0;
            amount_q   <= '0;
            valid_q    <= 1'b0;
            cancel_q   <= 1'b0;
            error_q    <= ERR_NONE;
        end else begin
            valid_q  <= 1'b0;
            cancel_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (kp.start) begin
                        mode_q  <= kp.mode;
                        buf_q   <= '0;
                        count_q <= '0;
                        timer_q <= '0;
                        error_q <= ERR_NONE;
                        state_q <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (kp.key_valid) begin
                        timer_q <= '0;
                        if (kp.key_code <= 4'd9) begin
                            if (count_q != limit) begin
                                buf_q   <= {buf_q[BW-5:0], kp.key_code};
                                count_q <= count_q + 3'd1;
                            end
                        end else begin
                            case (kp.key_code)
                                KEY_CLEAR: begin
                                    buf_q   <= '0;
                                    count_q <= '0;
                                end
                                KEY_BACK: begin
                                    if (count_q != 3'd0) begin
                                        buf_q   <= buf_q >> 4;
                                        count_q <= count_q - 3'd1;
                                    end
                                end
                                KEY_CANCEL: begin
                                    cancel_q <= 1'b1;
                                    state_q  <= IDLE;
                                end
                                KEY_ENTER: begin
                                    if (!mode_q) begin
                                        if (count_q == PIN_CNT) begin
                                            pin_q   <= buf_q[15:0];
                                            state_q <= DONE;
                                        end else begin
                                            error_q <= ERR_SHORT;
                                        end
                                    end else if (count_q == 3'd0) begin
                                        error_q <= ERR_SHORT;
                                    end else begin
                                        acc_q      <= '0;
                                        conv_idx_q <= '0;
                                        state_q    <= CONVERT;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else if (timer_q == TLAST) begin
                        error_q  <= ERR_TIMEOUT;
                        cancel_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                // The buffer is rotated one nibble per cycle; after AMT_DIGITS rotations it is
                // back in its original order, so an overflow can return to COLLECT with digits kept.
                CONVERT: begin
                    buf_q <= {buf_q[BW-5:0], digit_msb};
                    acc_q <= acc_d;
                    if (conv_idx_q == LAST_IDX) begin
                        conv_idx_q <= '0;
                        timer_q    <= '0;
                        if (acc_d[16]) begin
                            error_q <= ERR_OVF;
                            state_q <= COLLECT;
                        end else begin
                            amount_q <= acc_d[15:0];
                            state_q  <= DONE;
                        end
                    end else begin
                        conv_idx_q <= conv_idx_q + 3'd1;
                    end
                end

                DONE: begin
                    valid_q <= 1'b1;
                    error_q <= ERR_NONE;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign kp.busy         = (state_q != IDLE);
    assign kp.digit_count  = count_q;
    assign kp.pin_input    = pin_q;
    assign kp.amount       = amount_q;
    assign kp.entry_valid  = valid_q;
    assign kp.entry_cancel = cancel_q;
    assign kp.entry_error  = error_q;
endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed scenarios plus randomized sessions
// checked against a digit-queue model of the entry rules.
module tb_keypad_entry;
    logic clk = 1'b0;
    logic rst;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int          digits[$];
    bit          mode_m;
    logic [7:0]  exp_err;
    logic [15:0] last_pin;
    logic [15:0] last_amt;

    keypad_entry_if kp();

    keypad_entry #(
        .PIN_DIGITS    (4),
        .AMT_DIGITS    (5),
        .TIMEOUT_CYCLES(1000),
        .TW            (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        kp.start     = 1'b0;
        kp.mode      = 1'b0;
        kp.key_valid = 1'b0;
        kp.key_code  = 4'h0;
    endtask

    function automatic int limit();
        return mode_m ? 5 : 4;
    endfunction

    function automatic logic [15:0] pin_value();
        logic [15:0] p = '0;
        foreach (digits[i]) p = {p[11:0], 4'(digits[i])};
        return p;
    endfunction

    function automatic int amt_value();
        int v = 0;
        foreach (digits[i]) v = v * 10 + digits[i];
        return v;
    endfunction

    task automatic do_start(input bit m);
        kp.start = 1'b1;
        kp.mode  = m;
        @(negedge clk);
        clear_inputs();
        digits.delete();
        mode_m  = m;
        exp_err = 8'h00;
        check("start_busy", kp.busy, 1);
        check("start_count", kp.digit_count, 0);
        check("start_err", kp.entry_error, 0);
    endtask

    // Edit/digit keys (and ignored E/F) in COLLECT; a stray start pulse may ride along.
    task automatic press(input logic [3:0] k, input bit rand_start);
        kp.key_valid = 1'b1;
        kp.key_code  = k;
        if (rand_start && $urandom_range(0, 5) == 0) begin
            kp.start = 1'b1;
            kp.mode  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        clear_inputs();
        if (k <= 4'd9) begin
            if (digits.size() < limit()) digits.push_back(int'(k));
        end else if (k == 4'hA) begin
            digits.delete();
        end else if (k == 4'hB) begin
            if (digits.size() > 0) void'(digits.pop_back());
        end
        check("key_count", kp.digit_count, digits.size());
        check("key_err", kp.entry_error, exp_err);
    endtask

    task automatic press_cancel();
        kp.key_valid = 1'b1;
        kp.key_code  = 4'hD;
        @(negedge clk);
        clear_inputs();
        check("cancel_pulse", kp.entry_cancel, 1);
        check("cancel_busy", kp.busy, 0);
        check("cancel_err", kp.entry_error, exp_err);
        @(negedge clk);
        check("cancel_once", kp.entry_cancel, 0);
    endtask

    // what: 0 = entry_valid, 1 = overflow error, 2 = entry_cancel. lat = -1 if never seen.
    task automatic wait_for(input int what, input int max_cyc, input bit inject, output int lat);
        bit hit;
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            if (inject && i <= 4) begin
                kp.key_valid = 1'($urandom_range(0, 1));
                kp.key_code  = 4'($urandom_range(0, 15));
                kp.start     = 1'($urandom_range(0, 1));
                kp.mode      = 1'($urandom_range(0, 1));
            end else begin
                clear_inputs();
            end
            @(negedge clk);
            case (what)
                0:       hit = kp.entry_valid;
                1:       hit = (kp.entry_error == 8'h07);
                default: hit = kp.entry_cancel;
            endcase
            if (hit) begin
                lat = i;
                break;
            end
        end
        clear_inputs();
    endtask

    task automatic do_enter(input bit inject, output bit ok);
        int          lat;
        int          v;
        logic [15:0] p;
        ok = 1'b0;
        kp.key_valid = 1'b1;
        kp.key_code  = 4'hC;
        @(negedge clk);
        clear_inputs();
        if (!mode_m) begin
            if (digits.size() != 4) begin
                exp_err = 8'h06;
                check("pin_short_err", kp.entry_error, exp_err);
                check("pin_short_count", kp.digit_count, digits.size());
                check("pin_short_busy", kp.busy, 1);
            end else begin
                p = pin_value();
                last_pin = p;
                wait_for(0, 20, 1'b0, lat);
                check("pin_latency", lat, 1);
                check("pin_value", kp.pin_input, p);
                check("pin_done_err", kp.entry_error, 0);
                check("pin_done_busy", kp.busy, 0);
                check("amt_hold", kp.amount, last_amt);
                @(negedge clk);
                check("pin_valid_once", kp.entry_valid, 0);
                ok = 1'b1;
            end
        end else if (digits.size() == 0) begin
            exp_err = 8'h06;
            check("amt_short_err", kp.entry_error, exp_err);
            check("amt_short_busy", kp.busy, 1);
        end else begin
            v = amt_value();
            if (v > 65535) begin
                exp_err = 8'h07;
                wait_for(1, 20, inject, lat);
                check("ovf_latency", lat, 5);
                check("ovf_count", kp.digit_count, digits.size());
                check("ovf_busy", kp.busy, 1);
                check("ovf_no_valid", kp.entry_valid, 0);
            end else begin
                last_amt = 16'(v);
                wait_for(0, 20, inject, lat);
                check("amt_latency", lat, 6);
                check("amt_value", kp.amount, v);
                check("amt_done_err", kp.entry_error, 0);
                check("pin_hold", kp.pin_input, last_pin);
                @(negedge clk);
                check("amt_valid_once", kp.entry_valid, 0);
                ok = 1'b1;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, kp.busy, 0);
        check({tag, "_count"}, kp.digit_count, 0);
        check({tag, "_pin"}, kp.pin_input, 0);
        check({tag, "_amt"}, kp.amount, 0);
        check({tag, "_valid"}, kp.entry_valid, 0);
        check({tag, "_cancel"}, kp.entry_cancel, 0);
        check({tag, "_err"}, kp.entry_error, 0);
    endtask

    initial begin
        bit          ok;
        int          lat;
        int          n;
        bit          seen;
        logic [3:0]  k;
        clear_inputs();
        last_pin = '0;
        last_amt = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // start and key together in IDLE: key is dropped
        kp.start = 1'b1; kp.mode = 1'b0; kp.key_valid = 1'b1; kp.key_code = 4'h7;
        @(negedge clk);
        clear_inputs();
        digits.delete(); mode_m = 1'b0; exp_err = 8'h00;
        check("start_key_drop", kp.digit_count, 0);
        foreach (digits[i]) ;
        press(4'h1, 0); press(4'h2, 0); press(4'h3, 0); press(4'h4, 0);
        press(4'h5, 0);
        do_enter(0, ok);

        do_start(0);
        press(4'h5, 0); press(4'h6, 0);
        do_enter(0, ok);
        press(4'h7, 0); press(4'h8, 0);
        do_enter(0, ok);

        do_start(1);
        press(4'h2, 0); press(4'h5, 0); press(4'h0, 0); press(4'h0, 0);
        do_enter(0, ok);

        do_start(1);
        repeat (6) press(4'h9, 0);
        do_enter(1, ok);
        press(4'hB, 0);
        do_enter(0, ok);

        do_start(1);
        do_enter(0, ok);
        press(4'h0, 0);
        do_enter(0, ok);

        // Inactivity timeout; an ignored F key still restarts the timer
        do_start(0);
        press(4'h3, 0);
        repeat (600) @(negedge clk);
        press(4'hF, 0);
        wait_for(2, 1100, 1'b0, lat);
        check("timeout_latency", lat, 1000);
        check("timeout_err", kp.entry_error, 8'h05);
        check("timeout_busy", kp.busy, 0);
        @(negedge clk);
        check("timeout_once", kp.entry_cancel, 0);

        do_start(0);
        press(4'h3, 0);
        press_cancel();
        do_start(0);
        press(4'h5, 0);
        do_enter(0, ok);
        press_cancel();

        do_start(0);
        press(4'hB, 0);
        press(4'h1, 0); press(4'h2, 0); press(4'hB, 0); press(4'hA, 0);
        press(4'h4, 0); press(4'h3, 0); press(4'h2, 0); press(4'h1, 0);
        do_enter(0, ok);

        for (int s = 0; s < 40; s++) begin
            do_start(1'($urandom_range(0, 1)));
            n = $urandom_range(0, 9);
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                case ($urandom_range(0, 19))
                    14:      k = 4'hA;
                    15, 16:  k = 4'hB;
                    17:      k = 4'($urandom_range(14, 15));
                    default: k = 4'($urandom_range(0, 9));
                endcase
                press(k, 1);
            end
            do_enter(1, ok);
            if (!ok) press_cancel();
        end

        // Asynchronous reset in the middle of CONVERT
        do_start(1);
        press(4'h1, 0); press(4'h2, 0);
        kp.key_valid = 1'b1; kp.key_code = 4'hC;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        last_pin = '0;
        last_amt = '0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (kp.entry_valid) seen = 1'b1;
        end
        check("no_valid_after_rst", seen, 0);
        check("idle_after_rst", kp.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
